// File: rtl/calc_input_ctrl_if.sv
// Bus between the raw calculator panel (master) and the input controller (slave):
// raw buttons/switches in, debounced levels, operands and operation event out.
interface calc_input_ctrl_if;
    logic       btn_soma_n;
    logic       btn_subt_n;
    logic       btn_mult_n;
    logic       btn_igual_n;
    logic [7:0] sw_a;
    logic [7:0] sw_b;
    logic       sw_sa;
    logic       sw_sb;
    logic       SOMA;
    logic       SUBT;
    logic       MULT;
    logic       IGUAL;
    logic [7:0] A;
    logic [7:0] B;
    logic       sinalA;
    logic       sinalB;
    logic       op_valid;
    logic [2:0] op_code;

    modport master (
        output btn_soma_n, btn_subt_n, btn_mult_n, btn_igual_n,
        output sw_a, sw_b, sw_sa, sw_sb,
        input  SOMA, SUBT, MULT, IGUAL,
        input  A, B, sinalA, sinalB,
        input  op_valid, op_code
    );

    modport slave (
        input  btn_soma_n, btn_subt_n, btn_mult_n, btn_igual_n,
        input  sw_a, sw_b, sw_sa, sw_sb,
        output SOMA, SUBT, MULT, IGUAL,
        output A, B, sinalA, sinalB,
        output op_valid, op_code
    );
endinterface

// File: rtl/calc_input_ctrl.sv
// Calculator input stage: synchronizes and debounces four buttons, reports operations.
// Define OPERAND_LATCH_EN to freeze A/B/signs on each accepted operation.
module calc_input_ctrl #(
    parameter int unsigned DEB_CYCLES = 500000
) (
    input logic              clk,
    input logic              rst,
    calc_input_ctrl_if.slave bus
);
    typedef enum logic [1:0] {REL, PCHK, PRS, RCHK} deb_state_t;

    // Entry into a check state already counts as the first stable sample.
    localparam logic [19:0] CNT_LAST = 20'(DEB_CYCLES - 2);
    localparam logic [19:0] CNT_SAT  = 20'(DEB_CYCLES - 1);

    logic [3:0]  w_btn_raw;
    logic [3:0]  r_btn_s1;
    logic [3:0]  r_btn_s2;
    logic [17:0] w_sw_raw;
    logic [17:0] r_sw_s1;
    logic [17:0] r_sw_s2;
    logic [17:0] w_opnd;

    deb_state_t  r_state [4];
    logic [19:0] r_cnt   [4];
    logic [3:0]  r_deb;
    logic [3:0]  w_release;
    logic        w_accept;
    logic [2:0]  w_code;
    logic        r_op_valid;
    logic [2:0]  r_op_code;

    assign w_btn_raw = {bus.btn_igual_n, bus.btn_mult_n, bus.btn_subt_n, bus.btn_soma_n};
    assign w_sw_raw  = {bus.sw_sb, bus.sw_sa, bus.sw_b, bus.sw_a};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_s1 <= '1;
            r_btn_s2 <= '1;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_btn_s1 <= w_btn_raw;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= w_sw_raw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    always_comb begin
        w_release = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_release[i] = (r_state[i] == RCHK) && r_btn_s2[i] && (r_cnt[i] >= CNT_LAST);
        end
    end

    always_comb begin
        w_code = '0;
        if (w_release[0])      w_code = 3'd1;
        else if (w_release[1]) w_code = 3'd2;
        else if (w_release[2]) w_code = 3'd3;
        else if (w_release[3]) w_code = 3'd4;
    end

    assign w_accept = |w_release;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                r_state[i] <= REL;
                r_cnt[i]   <= '0;
            end
            r_deb <= '1;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                case (r_state[i])
                    REL: begin
                        if (!r_btn_s2[i]) begin
                            r_state[i] <= PCHK;
                            r_cnt[i]   <= '0;
                        end
                    end
                    PCHK: begin
                        if (r_btn_s2[i]) begin
                            r_state[i] <= REL;
                            r_cnt[i]   <= '0;
                        end else if (r_cnt[i] >= CNT_LAST) begin
                            r_state[i] <= PRS;
                            r_cnt[i]   <= '0;
                            r_deb[i]   <= 1'b0;
                        end else if (r_cnt[i] != CNT_SAT) begin
                            r_cnt[i] <= r_cnt[i] + 20'd1;
                        end
                    end
                    PRS: begin
                        if (r_btn_s2[i]) begin
                            r_state[i] <= RCHK;
                            r_cnt[i]   <= '0;
                        end
                    end
                    RCHK: begin
                        if (!r_btn_s2[i]) begin
                            r_state[i] <= PRS;
                            r_cnt[i]   <= '0;
                        end else if (r_cnt[i] >= CNT_LAST) begin
                            r_state[i] <= REL;
                            r_cnt[i]   <= '0;
                            r_deb[i]   <= 1'b1;
                        end else if (r_cnt[i] != CNT_SAT) begin
                            r_cnt[i] <= r_cnt[i] + 20'd1;
                        end
                    end
                    default: begin
                        r_state[i] <= REL;
                        r_cnt[i]   <= '0;
                        r_deb[i]   <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Lower-priority releases in the same clock are dropped, not queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_valid <= 1'b0;
            r_op_code  <= '0;
        end else begin
            r_op_valid <= w_accept;
            if (w_accept) r_op_code <= w_code;
        end
    end

`ifdef OPERAND_LATCH_EN
    logic [17:0] r_opnd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_opnd <= '0;
        else if (w_accept) r_opnd <= r_sw_s2;
    end

    assign w_opnd = r_opnd;
`else
    assign w_opnd = r_sw_s2;
`endif

    assign bus.SOMA     = r_deb[0];
    assign bus.SUBT     = r_deb[1];
    assign bus.MULT     = r_deb[2];
    assign bus.IGUAL    = r_deb[3];
    assign bus.A        = w_opnd[7:0];
    assign bus.B        = w_opnd[15:8];
    assign bus.sinalA   = w_opnd[16];
    assign bus.sinalB   = w_opnd[17];
    assign bus.op_valid = r_op_valid;
    assign bus.op_code  = r_op_code;
endmodule

// File: tb/tb_calc_input_ctrl.sv
// Directed bench for calc_input_ctrl with DEB_CYCLES=4 (debounce latency 6 clocks).
// Operand expectations follow OPERAND_LATCH_EN when the build defines it.
module tb_calc_input_ctrl;
    localparam int unsigned DEB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned n_bad_lvl;
    int unsigned n_pulse;
    logic [2:0]  pulse_code;
    logic        found;

    calc_input_ctrl_if bus_if ();

    calc_input_ctrl #(.DEB_CYCLES(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus_if.btn_soma_n  = 1'b1;
        bus_if.btn_subt_n  = 1'b1;
        bus_if.btn_mult_n  = 1'b1;
        bus_if.btn_igual_n = 1'b1;
        bus_if.sw_a        = 8'd0;
        bus_if.sw_b        = 8'd0;
        bus_if.sw_sa       = 1'b0;
        bus_if.sw_sb       = 1'b0;

        // Reset state
        #45;
        chk("rst_levels", {bus_if.SOMA, bus_if.SUBT, bus_if.MULT, bus_if.IGUAL}, 4'hF);
        chk("rst_operands", {bus_if.sinalB, bus_if.sinalA, bus_if.B, bus_if.A}, 0);
        chk("rst_op_valid", bus_if.op_valid, 0);
        chk("rst_op_code", bus_if.op_code, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(3);

        // Clean SOMA press held 10 clocks then released
        bus_if.btn_soma_n = 1'b0;
        tick(5);
        chk("soma_press_t5", bus_if.SOMA, 1);
        tick(1);
        chk("soma_press_t6", bus_if.SOMA, 0);
        tick(4);
        bus_if.btn_soma_n = 1'b1;
        tick(5);
        chk("soma_rel_t5", bus_if.SOMA, 0);
        chk("soma_rel_t5_opv", bus_if.op_valid, 0);
        tick(1);
        chk("soma_rel_t6", bus_if.SOMA, 1);
        chk("soma_opv_pulse", bus_if.op_valid, 1);
        chk("soma_op_code", bus_if.op_code, 1);
        tick(1);
        chk("soma_opv_one_clk", bus_if.op_valid, 0);
        chk("soma_op_code_hold", bus_if.op_code, 1);

        // MULT bouncing: 2 clocks low, 1 high, 10 periods, then held high
        n_bad_lvl = 0;
        n_pulse   = 0;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 3; j++) begin
                bus_if.btn_mult_n = (j == 2);
                tick(1);
                if (bus_if.MULT !== 1'b1) n_bad_lvl++;
                if (bus_if.op_valid !== 1'b0) n_pulse++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus_if.MULT !== 1'b1) n_bad_lvl++;
            if (bus_if.op_valid !== 1'b0) n_pulse++;
        end
        chk("bounce_mult_level", n_bad_lvl, 0);
        chk("bounce_no_op_valid", n_pulse, 0);

        // SUBT and IGUAL pressed/released together
        bus_if.btn_subt_n  = 1'b0;
        bus_if.btn_igual_n = 1'b0;
        tick(6);
        chk("dual_subt_low", bus_if.SUBT, 0);
        chk("dual_igual_low", bus_if.IGUAL, 0);
        tick(4);
        bus_if.btn_subt_n  = 1'b1;
        bus_if.btn_igual_n = 1'b1;
        n_pulse    = 0;
        pulse_code = 3'd0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (bus_if.op_valid === 1'b1) begin
                n_pulse++;
                pulse_code = bus_if.op_code;
            end
        end
        chk("dual_one_pulse", n_pulse, 1);
        chk("dual_code_subt", pulse_code, 2);
        chk("dual_igual_high", bus_if.IGUAL, 1);
        chk("dual_subt_high", bus_if.SUBT, 1);

        // Reset mid-PCHK on SOMA, button kept pressed
        bus_if.btn_soma_n = 1'b0;
        tick(3);
        rst = 1'b1;
        #1;
        chk("midrst_soma", bus_if.SOMA, 1);
        chk("midrst_op_code", bus_if.op_code, 0);
        tick(2);
        chk("midrst_opv", bus_if.op_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        n_pulse = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (bus_if.op_valid !== 1'b0) n_pulse++;
        end
        chk("midrst_requal_t5", bus_if.SOMA, 1);
        chk("midrst_no_opv", n_pulse, 0);
        tick(1);
        chk("midrst_requal_t6", bus_if.SOMA, 0);
        bus_if.btn_soma_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick(1);
            if (bus_if.op_valid === 1'b1) found = 1'b1;
        end
        chk("midrst_release_opv", found, 1);
        chk("midrst_release_code", bus_if.op_code, 1);

        // Operand path
        bus_if.sw_a  = 8'd200;
        bus_if.sw_b  = 8'd55;
        bus_if.sw_sa = 1'b1;
        tick(1);
        chk("opnd_lat_t1", bus_if.A, 0);
        tick(1);
`ifdef OPERAND_LATCH_EN
        chk("opnd_before_op_A", bus_if.A, 0);
        chk("opnd_before_op_B", bus_if.B, 0);
`else
        chk("opnd_follow_A", bus_if.A, 200);
        chk("opnd_follow_sA", bus_if.sinalA, 1);
`endif
        bus_if.btn_igual_n = 1'b0;
        tick(8);
        bus_if.btn_igual_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick(1);
            if (bus_if.op_valid === 1'b1) found = 1'b1;
        end
        chk("igual_opv", found, 1);
        chk("igual_code", bus_if.op_code, 4);
        chk("igual_A", bus_if.A, 200);
        chk("igual_B", bus_if.B, 55);
        chk("igual_sA", bus_if.sinalA, 1);
        bus_if.sw_a = 8'd7;
        tick(1);
        chk("sw_change_t1", bus_if.A, 200);
        tick(1);
`ifdef OPERAND_LATCH_EN
        chk("sw_change_hold_A", bus_if.A, 200);
        chk("sw_change_hold_B", bus_if.B, 55);
`else
        chk("sw_change_follow_A", bus_if.A, 7);
        chk("sw_change_follow_B", bus_if.B, 55);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
